// File: rtl/store_buffer.sv
// Store buffer between the M-stage and data memory: formats stores into lane-aligned
// word writes, queues them in a FIFO and drains them one at a time with a req/ack handshake.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_ready,
  output logic        st_misaligned,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   head, tail, load_idx;
  logic [CNT_W-1:0]   count;
  logic [DEPTH-1:0]   ent_vld;
  logic [29:0]        ent_addr  [DEPTH];
  logic [31:0]        ent_wdata [DEPTH];
  logic [3:0]         ent_wstrb [DEPTH];
  logic [29:0]        mem_addr_q;
  logic               enq, pop, more, load, bypass;
  logic [31:0]        enq_wdata;
  logic [3:0]         enq_wstrb;
  logic [DEPTH-1:0]   hit;
  logic               ld_addr_unused;

  function automatic logic [31:0] fmt_wdata(input logic [31:0] data, input logic [1:0] size);
    case (size)
      2'b00:   fmt_wdata = {4{data[7:0]}};
      2'b01:   fmt_wdata = {2{data[15:0]}};
      default: fmt_wdata = data;
    endcase
  endfunction

  function automatic logic [3:0] fmt_wstrb(input logic [1:0] addr_lo, input logic [1:0] size);
    case (size)
      2'b00:   fmt_wstrb = 4'b0001 << addr_lo;
      2'b01:   fmt_wstrb = 4'b0011 << addr_lo;
      default: fmt_wstrb = 4'b1111;
    endcase
  endfunction

  assign st_ready      = (count < FULL_CNT);
  assign st_misaligned = st_valid &&
                         (((st_size == 2'b01) && st_addr[0]) ||
                          (st_size[1] && (st_addr[1:0] != 2'b00)));
  assign enq           = st_valid && st_ready && !st_misaligned;
  assign enq_wdata     = fmt_wdata(st_data, st_size);
  assign enq_wstrb     = fmt_wstrb(st_addr[1:0], st_size);
  assign empty         = (count == '0) && (state == IDLE);
  assign mem_addr      = {mem_addr_q, 2'b00};
  assign ld_addr_unused = ^ld_addr[1:0];

  // Entries still waiting for their ack (including the in-flight head) block matching loads
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = ent_vld[i] && (ent_addr[i] == ld_addr[31:2]);
    end
  end
  assign ld_conflict = ld_valid && (|hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0)     state_nxt = BUSY;
      BUSY:    if (mem_ack && !more) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With a single entry left, the only successor is the store arriving this cycle
  always_comb begin
    pop      = (state == BUSY) && mem_ack;
    more     = (count > ONE_CNT) || enq;
    load     = ((state == IDLE) && (count != '0)) || (pop && more);
    bypass   = pop && (count == ONE_CNT);
    load_idx = (state == IDLE) ? head : head + PTR_W'(1);
    mem_req  = (state == BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (enq) begin
        tail          <= tail + PTR_W'(1);
        ent_vld[tail] <= 1'b1;
      end
      if (pop) begin
        head          <= head + PTR_W'(1);
        ent_vld[head] <= 1'b0;
      end
      case ({enq, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail]  <= st_addr[31:2];
      ent_wdata[tail] <= enq_wdata;
      ent_wstrb[tail] <= enq_wstrb;
    end
  end

  // Write-port registers: held stable while BUSY until the ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else if (load) begin
      if (bypass) begin
        mem_addr_q <= st_addr[31:2];
        mem_wdata  <= enq_wdata;
        mem_wstrb  <= enq_wstrb;
      end else begin
        mem_addr_q <= ent_addr[load_idx];
        mem_wdata  <= ent_wdata[load_idx];
        mem_wstrb  <= ent_wstrb[load_idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: formatting, fill/backpressure, back-to-back drain,
// load conflict and asynchronous reset.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_ready;
  logic        st_misaligned;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic        empty;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_ready(st_ready), .st_misaligned(st_misaligned),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .empty(empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0;
    #2;
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ld_conflict", 32'(ld_conflict), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // byte store
    put(32'h103, 32'h0000_00AB, 2'b00);
    #1 chk("byte_misaligned", 32'(st_misaligned), 32'd0);
    tick;
    st_valid = 1'b0;
    chk("byte_lat_req", 32'(mem_req), 32'd0);
    chk("byte_not_empty", 32'(empty), 32'd0);
    tick;
    chk("byte_req", 32'(mem_req), 32'd1);
    chk("byte_addr", mem_addr, 32'h100);
    chk("byte_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("byte_wstrb", 32'(mem_wstrb), 32'h8);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("byte_done_req", 32'(mem_req), 32'd0);
    chk("byte_done_empty", 32'(empty), 32'd1);

    // misaligned half dropped, aligned half accepted
    put(32'h201, 32'h1234, 2'b01);
    #1 chk("half_misaligned", 32'(st_misaligned), 32'd1);
    tick;
    st_valid = 1'b0;
    chk("half_mis_empty", 32'(empty), 32'd1);
    tick;
    chk("half_mis_noreq", 32'(mem_req), 32'd0);
    put(32'h202, 32'h1234, 2'b01);
    tick;
    st_valid = 1'b0;
    tick;
    chk("half_addr", mem_addr, 32'h200);
    chk("half_wdata", mem_wdata, 32'h1234_1234);
    chk("half_wstrb", 32'(mem_wstrb), 32'hC);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("half_done_empty", 32'(empty), 32'd1);

    // fill with ack low, fifth store refused
    for (int i = 0; i < 4; i++) begin
      put(32'h400 + 32'(4 * i), 32'hD000_0000 + 32'(i), 2'b10);
      #1 chk("fill_ready", 32'(st_ready), 32'd1);
      tick;
    end
    put(32'h500, 32'hDEAD_BEEF, 2'b10);
    #1 chk("full_ready", 32'(st_ready), 32'd0);
    tick;
    st_valid = 1'b0;
    chk("full_head_addr", mem_addr, 32'h400);
    chk("full_head_wdata", mem_wdata, 32'hD000_0000);
    mem_ack = 1'b1;
    #1 chk("full_pop_ready", 32'(st_ready), 32'd0);
    tick;
    mem_ack = 1'b0;
    chk("after_pop_ready", 32'(st_ready), 32'd1);
    chk("order_1_addr", mem_addr, 32'h404);
    chk("order_1_wdata", mem_wdata, 32'hD000_0001);
    mem_ack = 1'b1;
    tick;
    chk("order_2_addr", mem_addr, 32'h408);
    tick;
    chk("order_3_addr", mem_addr, 32'h40C);
    chk("order_3_wstrb", 32'(mem_wstrb), 32'hF);
    tick;
    mem_ack = 1'b0;
    chk("fill_drained_req", 32'(mem_req), 32'd0);
    chk("fill_drained_empty", 32'(empty), 32'd1);

    // back-to-back drain with ack held high
    mem_ack = 1'b1;
    put(32'h600, 32'h6, 2'b10);
    tick;
    put(32'h604, 32'h7, 2'b10);
    tick;
    chk("b2b_0_addr", mem_addr, 32'h600);
    chk("b2b_0_req", 32'(mem_req), 32'd1);
    put(32'h608, 32'h8, 2'b10);
    tick;
    st_valid = 1'b0;
    chk("b2b_1_addr", mem_addr, 32'h604);
    chk("b2b_1_req", 32'(mem_req), 32'd1);
    tick;
    chk("b2b_2_addr", mem_addr, 32'h608);
    chk("b2b_2_wdata", mem_wdata, 32'h8);
    tick;
    chk("b2b_end_req", 32'(mem_req), 32'd0);
    chk("b2b_end_empty", 32'(empty), 32'd1);
    mem_ack = 1'b0;

    // last entry acked while a new store arrives: next write follows without a bubble
    put(32'h700, 32'h70, 2'b10);
    tick;
    st_valid = 1'b0;
    tick;
    chk("byp_first_addr", mem_addr, 32'h700);
    put(32'h705, 32'h0000_00C3, 2'b00);
    mem_ack = 1'b1;
    tick;
    st_valid = 1'b0;
    mem_ack = 1'b0;
    chk("byp_req", 32'(mem_req), 32'd1);
    chk("byp_addr", mem_addr, 32'h704);
    chk("byp_wdata", mem_wdata, 32'hC3C3_C3C3);
    chk("byp_wstrb", 32'(mem_wstrb), 32'h2);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("byp_end_empty", 32'(empty), 32'd1);

    // load conflict
    put(32'h300, 32'h3, 2'b10);
    ld_valid = 1'b1;
    ld_addr  = 32'h300;
    #1 chk("conf_same_cycle", 32'(ld_conflict), 32'd0);
    tick;
    st_valid = 1'b0;
    ld_addr  = 32'h302;
    #1 chk("conf_pending", 32'(ld_conflict), 32'd1);
    tick;
    chk("conf_inflight", 32'(ld_conflict), 32'd1);
    ld_addr = 32'h304;
    #1 chk("conf_other_word", 32'(ld_conflict), 32'd0);
    ld_addr = 32'h302;
    ld_valid = 1'b0;
    #1 chk("conf_no_ld_valid", 32'(ld_conflict), 32'd0);
    ld_valid = 1'b1;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("conf_after_ack", 32'(ld_conflict), 32'd0);
    ld_valid = 1'b0;

    // asynchronous reset while busy with three entries
    for (int i = 0; i < 3; i++) begin
      put(32'h800 + 32'(4 * i), 32'h80 + 32'(i), 2'b10);
      tick;
    end
    st_valid = 1'b0;
    tick;
    chk("rstb_busy_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstb_req_async", 32'(mem_req), 32'd0);
    chk("rstb_empty", 32'(empty), 32'd1);
    chk("rstb_addr", mem_addr, 32'h0);
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rstb_no_replay", 32'(mem_req), 32'd0);
      chk("rstb_post_empty", 32'(empty), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of store buffer entries; legal values are powers of two, 2 to 8.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port st_valid, input, 1 bit, M-stage store request (memaccess MEM_WRITE, not flushed).
REQ-005 The block SHALL have port st_addr, input, 32 bits, store byte address.
REQ-006 The block SHALL have port st_data, input, 32 bits, store data after M-stage store-data forwarding.
REQ-007 The block SHALL have port st_size, input, 2 bits, access size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-008 The block SHALL have port st_ready, output, 1 bit, high when the buffer can accept a store.
REQ-009 The block SHALL have port st_misaligned, output, 1 bit, combinational misalignment flag for the current request.
REQ-010 The block SHALL have port ld_valid, input, 1 bit, M-stage load query.
REQ-011 The block SHALL have port ld_addr, input, 32 bits, load byte address.
REQ-012 The block SHALL have port ld_conflict, output, 1 bit, load must stall because a pending store targets the same word.
REQ-013 The block SHALL have port mem_req, output, 1 bit, data-memory write request.
REQ-014 The block SHALL have port mem_addr, output, 32 bits, word-aligned write address (bits [1:0] = 0).
REQ-015 The block SHALL have port mem_wdata, output, 32 bits, lane-aligned write data.
REQ-016 The block SHALL have port mem_wstrb, output, 4 bits, byte write enables.
REQ-017 The block SHALL have port mem_ack, input, 1 bit, memory accepts the current write.
REQ-018 The block SHALL have port empty, output, 1 bit, no pending or in-flight stores (used for fence/drain).

Function
REQ-019 st_ready SHALL equal (count < DEPTH) combinationally; a pop in the same cycle SHALL NOT raise st_ready when the buffer is full.
REQ-020 st_misaligned SHALL be high when st_valid is high and either (half with st_addr[0]=1) or (word with st_addr[1:0]!=0).
REQ-021 An enqueue SHALL occur exactly when st_valid && st_ready && !st_misaligned; misaligned stores SHALL be dropped without a state change.
REQ-022 Enqueue formatting, byte: wdata = {4{st_data[7:0]}}, wstrb = 4'b0001 << st_addr[1:0].
REQ-023 Enqueue formatting, half: wdata = {2{st_data[15:0]}}, wstrb = 4'b0011 << st_addr[1:0].
REQ-024 Enqueue formatting, word: wdata = st_data, wstrb = 4'b1111.
REQ-025 Every entry SHALL store addr[31:2], wdata and wstrb.
REQ-026 The buffer SHALL be a FIFO with head and tail pointers that wrap modulo DEPTH, and count in the range 0..DEPTH.
REQ-027 The drain FSM SHALL have two states, IDLE and BUSY.
REQ-028 In IDLE with count>0, the FSM SHALL register the head entry into mem_addr/mem_wdata/mem_wstrb, set mem_req=1 and go to BUSY.
REQ-029 In BUSY, mem_req and the address/data/strobe outputs SHALL stay stable until mem_ack.
REQ-030 On mem_ack in BUSY, the head entry SHALL pop.
REQ-031 After the pop, if entries remain (counting a same-cycle enqueue), the next head SHALL load directly and the FSM SHALL stay BUSY (back-to-back, no bubble); otherwise mem_req SHALL go to 0 and the FSM SHALL return to IDLE.
REQ-032 mem_ack SHALL be ignored in IDLE.
REQ-033 Latency: a store enqueued at edge N into an empty IDLE buffer SHALL produce mem_req=1 after edge N+1.
REQ-034 A simultaneous enqueue and pop SHALL leave count unchanged and move both pointers.
REQ-035 ld_conflict SHALL be ld_valid AND (any valid entry's addr[31:2] == ld_addr[31:2]), combinational; the in-flight entry SHALL count as valid until its ack edge.
REQ-036 A store being enqueued in the same cycle SHALL NOT contribute to ld_conflict.
REQ-037 empty SHALL equal (count==0 && state==IDLE).

Reset
REQ-038 While rst_n=0 (asynchronously), head, tail and count SHALL be 0, the FSM SHALL be IDLE, mem_req=0, mem_addr=0, mem_wdata=0 and mem_wstrb=0, giving st_ready=1, ld_conflict=0 and empty=1.
REQ-039 A reset asserted mid-transaction SHALL drop mem_req immediately and discard all entries; no write SHALL be replayed after release.

Verification
REQ-040 Byte store: st_addr=0x103, st_data=0x000000AB, st_size=00 -> the next cycle gives mem_req=1, mem_addr=0x100, mem_wdata=0xABABABAB, mem_wstrb=4'b1000.
REQ-041 Half store: st_addr=0x202, st_data=0x1234, st_size=01 -> mem_wdata=0x12341234, mem_wstrb=4'b1100; st_addr=0x201 half -> st_misaligned=1, count stays 0.
REQ-042 Fill with mem_ack=0: 4 word stores -> st_ready=0 after the 4th; a 5th store is not accepted; ack once -> st_ready=1 on the following cycle; the drain order matches the enqueue order.
REQ-043 Back-to-back with mem_ack held 1 and 3 stores queued: three consecutive cycles of ack, each with a new mem_addr, then mem_req=0 and empty=1.
REQ-044 Conflict: a pending store to 0x300 and a load at 0x302 -> ld_conflict=1; after the ack edge -> ld_conflict=0; a load at 0x304 -> 0.
REQ-045 Reset pulse while BUSY with 3 entries -> mem_req=0 asynchronously, empty=1 after release, no further mem_req without a new store.
